// File: rtl/alu_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for alu_arbiter.
// slave is the arbiter's view; master is the surrounding requesters/ALU/consumer.
interface alu_arbiter_if #(
    parameter int Width   = 4,
    parameter int OpWidth = 4
);
    logic                 req0_valid;
    logic                 req1_valid;
    logic                 req0_ready;
    logic                 req1_ready;
    logic [Width-1:0]     req0_a;
    logic [Width-1:0]     req0_b;
    logic [Width-1:0]     req1_a;
    logic [Width-1:0]     req1_b;
    logic [OpWidth-1:0]   req0_op;
    logic [OpWidth-1:0]   req1_op;

    logic [Width-1:0]     alu_a;
    logic [Width-1:0]     alu_b;
    logic [OpWidth-1:0]   alu_op;
    logic                 alu_enable;
    logic [2*Width-1:0]   alu_out;
    logic                 alu_cout;
    logic                 alu_borrow;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2*Width-1:0]   rsp_data;
    logic                 rsp_id;
    logic                 rsp_cout;
    logic                 rsp_borrow;
    logic                 rsp_err;
    logic [7:0]           done_cnt;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
        input  alu_out, alu_cout, alu_borrow, rsp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_op, alu_enable,
        output rsp_valid, rsp_data, rsp_id, rsp_cout, rsp_borrow, rsp_err, done_cnt
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
        output alu_out, alu_cout, alu_borrow, rsp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_op, alu_enable,
        input  rsp_valid, rsp_data, rsp_id, rsp_cout, rsp_borrow, rsp_err, done_cnt
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters,
// returning one response at a time with a saturating completion counter.
module alu_arbiter #(
    parameter int Width   = 4,
    parameter int OpWidth = 4
) (
    input logic          clk,
    input logic          arst,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t               state;
    state_t               state_nx;

    logic                 last_grant;
    logic [Width-1:0]     a_q;
    logic [Width-1:0]     b_q;
    logic [OpWidth-1:0]   op_q;
    logic [2*Width-1:0]   rsp_data_q;
    logic                 rsp_id_q;
    logic                 rsp_cout_q;
    logic                 rsp_borrow_q;
    logic                 rsp_err_q;
    logic [7:0]           done_q;

    logic                 grant0;
    logic                 grant1;
    logic                 ready0;
    logic                 ready1;
    logic                 accept;
    logic                 enable;
    logic                 rsp_valid;
    logic [Width-1:0]     sel_a;
    logic [Width-1:0]     sel_b;
    logic [OpWidth-1:0]   sel_op;
    logic                 sel_legal;

    // On a tie the requester that did not win last time is granted.
    assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
    assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);

    assign sel_a     = grant1 ? bus.req1_a  : bus.req0_a;
    assign sel_b     = grant1 ? bus.req1_b  : bus.req0_b;
    assign sel_op    = grant1 ? bus.req1_op : bus.req0_op;
    assign sel_legal = (sel_op <= OpWidth'(9));
    assign accept    = ready0 || ready1;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ready0    = 1'b0;
        ready1    = 1'b0;
        enable    = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                ready0 = grant0;
                ready1 = grant1;
                if (grant0 || grant1) begin
                    state_nx = sel_legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                enable   = 1'b1;
                state_nx = CAPTURE;
            end
            CAPTURE: begin
                state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            last_grant   <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            rsp_cout_q   <= 1'b0;
            rsp_borrow_q <= 1'b0;
            rsp_err_q    <= 1'b0;
            done_q       <= '0;
        end else begin
            if (accept) begin
                a_q        <= sel_a;
                b_q        <= sel_b;
                op_q       <= sel_op;
                last_grant <= grant1;
                rsp_id_q   <= grant1;
                // Illegal opcodes bypass the ALU; their response is fixed here.
                if (!sel_legal) begin
                    rsp_data_q   <= '0;
                    rsp_err_q    <= 1'b1;
                    rsp_cout_q   <= 1'b0;
                    rsp_borrow_q <= 1'b0;
                end
            end
            if (state == CAPTURE) begin
                rsp_data_q   <= bus.alu_out;
                rsp_cout_q   <= bus.alu_cout;
                rsp_borrow_q <= bus.alu_borrow;
                rsp_err_q    <= 1'b0;
            end
            if (rsp_valid && bus.rsp_ready && (done_q != 8'hFF)) begin
                done_q <= done_q + 8'd1;
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.alu_enable = enable;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_cout   = rsp_cout_q;
    assign bus.rsp_borrow = rsp_borrow_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.done_cnt   = done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, scored against
// a transaction-level model of grant order, latency and response contents.
module tb_alu_arbiter;

    localparam int W  = 4;
    localparam int OW = 4;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.Width(W), .OpWidth(OW)) bus ();

    alu_arbiter #(.Width(W), .OpWidth(OW)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU: returns {cout, borrow, result}.
    function automatic logic [9:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] op);
        logic [7:0] o;
        logic       c;
        logic       br;
        o  = '0;
        c  = 1'b0;
        br = 1'b0;
        case (op)
            4'd0: begin o = {4'b0, a} + {4'b0, b}; c = o[4]; end
            4'd1: begin o = {4'b0, a} - {4'b0, b}; br = (a < b); end
            4'd2: o = {4'b0, a} * {4'b0, b};
            4'd3: o = {4'b0, a & b};
            4'd4: o = {4'b0, a | b};
            4'd5: o = {4'b0, a ^ b};
            4'd6: o = {4'b0, ~a};
            4'd7: o = {4'b0, ~(a ^ b)};
            4'd8: o = {4'b0, a} << b;
            4'd9: o = {4'b0, a} >> b;
            default: o = '0;
        endcase
        return {c, br, o};
    endfunction

    // The shared synchronous ALU lives in the bench.
    always @(posedge clk) begin
        if (bus.alu_enable) begin
            {bus.alu_cout, bus.alu_borrow, bus.alu_out} <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
        end
    end

    // Model: one transaction in flight, aged in cycles since acceptance.
    bit         m_busy;
    int         m_age;
    bit         m_legal;
    bit         m_id;
    bit         m_last;
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [3:0] m_op;
    int         m_done;
    int         n_rsp;

    task automatic model_reset();
        m_busy = 0;
        m_age  = 0;
        m_last = 1;
        m_done = 0;
        n_rsp  = 0;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next one.
    task automatic cycle();
        bit         g_any;
        bit         g_id;
        bit         rv;
        logic [9:0] r;
        #1;
        g_any = !m_busy && (bus.req0_valid || bus.req1_valid);
        g_id  = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
        check("req0_ready", 32'(bus.req0_ready), 32'(g_any && !g_id));
        check("req1_ready", 32'(bus.req1_ready), 32'(g_any && g_id));
        rv = m_busy && (m_age >= (m_legal ? 3 : 1));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(rv));
        check("alu_enable", 32'(bus.alu_enable), 32'(m_busy && m_legal && m_age == 1));
        if (m_busy && m_legal && (m_age == 1 || m_age == 2))
            check("alu_operands", 32'({bus.alu_a, bus.alu_b, bus.alu_op}), 32'({m_a, m_b, m_op}));
        if (rv) begin
            r = m_legal ? alu_ref(m_a, m_b, m_op) : 10'd0;
            check("rsp_data", 32'(bus.rsp_data), 32'(r[7:0]));
            check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
            check("rsp_err", 32'(bus.rsp_err), 32'(!m_legal));
            check("rsp_cout", 32'(bus.rsp_cout), 32'(r[9]));
            check("rsp_borrow", 32'(bus.rsp_borrow), 32'(r[8]));
        end
        check("done_cnt", 32'(bus.done_cnt), 32'(m_done));
        if (g_any) begin
            m_busy  = 1;
            m_age   = 1;
            m_id    = g_id;
            m_last  = g_id;
            m_a     = g_id ? bus.req1_a  : bus.req0_a;
            m_b     = g_id ? bus.req1_b  : bus.req0_b;
            m_op    = g_id ? bus.req1_op : bus.req0_op;
            m_legal = (m_op <= 4'd9);
        end else if (m_busy) begin
            if (rv && bus.rsp_ready) begin
                m_busy = 0;
                n_rsp++;
                if (m_done < 255) m_done++;
            end else begin
                m_age++;
            end
        end
        @(negedge clk);
        if (g_any) begin
            if (g_id) bus.req1_valid = 1'b0;
            else      bus.req0_valid = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        check({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
        check({tag, "_rsp_flags"}, 32'({bus.rsp_id, bus.rsp_cout, bus.rsp_borrow, bus.rsp_err}), 0);
        check({tag, "_done_cnt"}, 32'(bus.done_cnt), 0);
        check({tag, "_alu_bus"}, 32'({bus.alu_a, bus.alu_b, bus.alu_op}), 0);
        check({tag, "_alu_enable"}, 32'(bus.alu_enable), 0);
    endtask

    task automatic do_reset();
        arst           = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        arst = 1'b1;
    endtask

    task automatic set_req(input int n, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        if (n == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((m_busy || bus.req0_valid || bus.req1_valid) && k < 50) begin
            cycle();
            k++;
        end
        check("drain_timeout", 32'(k < 50), 1);
    endtask

    int d0;
    int guard;

    initial begin
        arst = 1'b0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp_ready = 1'b0;
        bus.alu_out = '0; bus.alu_cout = 1'b0; bus.alu_borrow = 1'b0;
        @(negedge clk);
        do_reset();

        // Single add through the full three-cycle path.
        set_req(0, 4'd3, 4'd4, 4'd0);
        bus.rsp_ready = 1'b1;
        #1 check("c31_ready0", 32'(bus.req0_ready), 1);
        cycle();
        bus.req0_a = 4'd9;
        cycle();
        cycle();
        #1;
        check("c31_data", 32'(bus.rsp_data), 7);
        check("c31_id_cout", 32'({bus.rsp_id, bus.rsp_cout}), 0);
        cycle();
        check("c31_done", 32'(bus.done_cnt), 1);

        // Simultaneous requests from reset: req0 first, then req1.
        do_reset();
        set_req(0, 4'd3, 4'd5, 4'd2);
        set_req(1, 4'd2, 4'd3, 4'd1);
        bus.rsp_ready = 1'b1;
        cycle(); cycle(); cycle();
        #1;
        check("c32_first_data", 32'(bus.rsp_data), 15);
        check("c32_first_id", 32'(bus.rsp_id), 0);
        cycle();
        cycle(); cycle(); cycle();
        #1;
        check("c32_second_nibble", 32'(bus.rsp_data[3:0]), 32'hF);
        check("c32_second_borrow", 32'(bus.rsp_borrow), 1);
        check("c32_second_id", 32'(bus.rsp_id), 1);
        cycle();

        // Illegal opcode answers after one cycle without touching the ALU.
        set_req(1, 4'd5, 4'd6, 4'hC);
        cycle();
        #1;
        check("c33_valid", 32'(bus.rsp_valid), 1);
        check("c33_err_data", 32'({bus.rsp_err, bus.rsp_data}), 32'h100);
        check("c33_enable", 32'(bus.alu_enable), 0);
        cycle();

        // Consumer stalls for five cycles while both requesters wait.
        bus.rsp_ready = 1'b0;
        set_req(0, 4'd9, 4'd8, 4'd0);
        cycle(); cycle(); cycle();
        set_req(0, 4'd1, 4'd2, 4'd4);
        set_req(1, 4'd7, 4'd1, 4'd5);
        d0 = m_done;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("c34_hold_valid", 32'(bus.rsp_valid), 1);
            check("c34_hold_data", 32'({bus.rsp_cout, bus.rsp_data}), 32'h111);
            check("c34_hold_ready", 32'({bus.req0_ready, bus.req1_ready}), 0);
            check("c34_hold_done", 32'(bus.done_cnt), 32'(d0));
            cycle();
        end
        bus.rsp_ready = 1'b1;
        cycle();
        check("c34_done", 32'(bus.done_cnt), 32'(d0 + 1));

        // Reset during CAPTURE of the next (req1) transaction.
        cycle(); cycle();
        check("c35_in_capture", 32'(m_age), 2);
        #2 arst = 1'b0;
        #1 check_zero("c35");
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        model_reset();
        #1 arst = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        check("c35_no_rsp", 32'({bus.rsp_valid, bus.done_cnt}), 0);
        set_req(0, 4'd2, 4'd2, 4'd0);
        set_req(1, 4'd4, 4'd4, 4'd0);
        #1 check("c35_grant0", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
        drain();

        // Random traffic until the counter saturates.
        do_reset();
        guard = 0;
        while (n_rsp < 260 && guard < 4000) begin
            if (!bus.req0_valid && ($urandom % 4 != 0))
                set_req(0, 4'($urandom), 4'($urandom), 4'($urandom_range(0, 11)));
            if (!bus.req1_valid && ($urandom % 4 != 0))
                set_req(1, 4'($urandom), 4'($urandom), 4'($urandom_range(0, 11)));
            bus.rsp_ready = ($urandom % 4 != 0);
            cycle();
            guard++;
        end
        check("c36_responses", 32'(n_rsp), 260);
        check("c36_done_sat", 32'(bus.done_cnt), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter Width, default 4, giving the ALU operand width in bits.
REQ-002 The block SHALL have parameter OpWidth, default 4, giving the ALU opcode width in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on posedge clk.
REQ-004 The block SHALL have port arst, input, 1, a reset that is asynchronous and active-low.
REQ-005 The block SHALL have ports req0_valid / req1_valid, input, 1, meaning requester N presents an operation.
REQ-006 The block SHALL have ports req0_ready / req1_ready, output, 1, meaning requester N's operation is accepted this cycle.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, Width, the operands.
REQ-008 The block SHALL have ports req0_op / req1_op, input, OpWidth, the ALU opcode (0000 add … 1001 right shift).
REQ-009 The block SHALL have ports alu_a / alu_b, output, Width, and alu_op, output, OpWidth, the operands and opcode driven to the shared synchronous ALU.
REQ-010 The block SHALL have port alu_enable, output, 1, the ALU enable.
REQ-011 The block SHALL have port alu_out, input, 2*Width, the registered ALU result.
REQ-012 The block SHALL have ports alu_cout / alu_borrow, input, 1, the ALU carry and borrow flags.
REQ-013 The block SHALL have port rsp_valid, output, 1, meaning a response is pending; it SHALL have port rsp_ready, input, 1, the consumer's acceptance of that response.
REQ-014 The block SHALL have ports rsp_data, output, 2*Width; rsp_id, output, 1 (requester index); rsp_cout, output, 1; rsp_borrow, output, 1; rsp_err, output, 1 (illegal opcode).
REQ-015 The block SHALL have port done_cnt, output, 8, the count of completed responses.

Function
REQ-016 The FSM SHALL have four states, IDLE, ISSUE, CAPTURE and RESP, with transitions IDLE->ISSUE on acceptance of a legal op, ISSUE->CAPTURE unconditionally, CAPTURE->RESP unconditionally, and RESP->IDLE when rsp_valid && rsp_ready.
REQ-017 An accepted op with opcode > 4'b1001 SHALL go IDLE->RESP directly with rsp_data=0, rsp_err=1, rsp_cout=0, rsp_borrow=0, and the ALU SHALL NOT be enabled.
REQ-018 reqN_ready SHALL be asserted combinationally only in IDLE, only for the granted requester, and only while that requester's reqN_valid is high; at most one ready SHALL be high per cycle.
REQ-019 Arbitration SHALL be round-robin: if only one requester is valid, it is granted; if both are valid, the requester other than last_grant is granted; last_grant SHALL update on each acceptance.
REQ-020 On acceptance the block SHALL latch a, b, op and id into internal registers; later changes on req inputs SHALL have no effect on the transaction in flight.
REQ-021 alu_a, alu_b and alu_op SHALL drive the latched values and SHALL hold them stable through ISSUE and CAPTURE.
REQ-022 alu_enable SHALL be 1 only in ISSUE.
REQ-023 In CAPTURE the block SHALL register alu_out into rsp_data, alu_cout into rsp_cout and alu_borrow into rsp_borrow, and set rsp_err=0.
REQ-024 Latency SHALL be exactly 3 cycles for a legal op: acceptance edge T, ISSUE during T+1, CAPTURE during T+2, rsp_valid high from T+3.
REQ-025 Latency SHALL be exactly 1 cycle for an illegal op: rsp_valid high from T+1.
REQ-026 rsp_valid SHALL stay high and rsp_data, rsp_id and all flags SHALL stay stable until rsp_ready is sampled high; no new request SHALL be accepted before RESP exits.
REQ-027 done_cnt SHALL increment by 1 on each response handshake, SHALL count illegal-op responses, and SHALL saturate at 255.
REQ-028 A requester that holds valid while not granted SHALL keep its request pending; there SHALL be no starvation, and each requester SHALL wait at most one transaction while the other is served.

Reset
REQ-029 While arst=0, the block SHALL immediately force state=IDLE, last_grant=1 (so req0 wins the first tie), and all registered outputs and latches to 0: rsp_valid, rsp_data, rsp_id, rsp_cout, rsp_borrow, rsp_err, done_cnt, alu_a, alu_b, alu_op, alu_enable.
REQ-030 A reset asserted mid-transaction SHALL drop that transaction silently: no response and no counter increment.

Verification
REQ-031 The bench SHALL cover this case: req0 add a=3, b=4, rsp_ready=1 -> req0_ready high at T; rsp_valid at T+3 with rsp_data=7, rsp_id=0, rsp_cout=0; done_cnt=1.
REQ-032 The bench SHALL cover this case: req0 and req1 both valid from reset with mult 3*5 and sub 2-3 -> req0 served first (rsp_data=15), then req1 (rsp_data=4'hF in the low nibble, rsp_borrow=1, rsp_id=1).
REQ-033 The bench SHALL cover this case: req1 op=4'b1100 -> rsp_valid at T+1 with rsp_err=1, rsp_data=0, and alu_enable never high.
REQ-034 The bench SHALL cover this case: rsp_ready held low for 5 cycles -> rsp_valid and rsp_data stable for all 5 cycles, both reqN_ready low, and done_cnt unchanged until the handshake.
REQ-035 The bench SHALL cover this case: arst pulsed low during CAPTURE -> all outputs 0 asynchronously, no response, and the next pair of simultaneous requests grants req0.
REQ-036 The bench SHALL cover this case: 260 back-to-back ops -> done_cnt=255.
